inst_feeder: RTL and testbench

- Instruction-supply end of the CPU fetch interface: answers the core's `pc` with `inst` and gates its PC advance via `pcEn`.
- Program words are first streamed in over a valid/ready load channel from the host/emulator side and stored in an internal buffer.
- Once started, the block serves fetches, then inserts NOPs to drain the five-stage pipeline, and halts the core.
- Sits between the testbench/host transactor and the CPU top.

---
 rtl/inst_feeder.sv | 112 +++++++++++
 tb/tb_inst_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_feeder.sv
// inst_feeder: loads a program over valid/ready, then answers core fetches (1-cycle registered inst),
// pads DRAIN NOPs past the program and halts. INST_FEEDER_RELOAD_EN lets load_valid in HALT restart loading.
module inst_feeder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DRAIN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  input  logic          start,
  input  logic [31:0]   pc,
  output logic [31:0]   inst,
  output logic          pcEn,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_HALT} state_t;

  localparam logic [AW:0]   CNT_LAST = DEPTH[AW:0] - 1'b1;
  localparam logic [AW+1:0] DRAIN_W  = DRAIN[AW+1:0];

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     inst_q, inst_d;
  logic            err_q, err_d;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [AW+1:0]   word_addr, drain_lim;
  logic            hi_zero, in_range, halt_hit, load_fire;

  // Low two pc bits are dropped, so a misaligned fetch returns the word containing it.
  assign idx       = pc[AW+1:2];
  assign hi_zero   = (pc[31:AW+2] == '0);
  assign in_range  = hi_zero && ({1'b0, idx} < count_q);
  assign word_addr = {2'b00, idx};
  assign drain_lim = {1'b0, count_q} + DRAIN_W;
  assign halt_hit  = !hi_zero || (word_addr >= drain_lim);
  assign load_fire = (state_q == S_LOAD) && load_valid;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    inst_d   = 32'h0;
    err_d    = err_q;
    unique case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (load_last || (count_q == CNT_LAST)) state_d = S_READY;
        end
      end
      S_READY: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        inst_d = in_range ? mem[idx] : 32'h0;
        if (pc[1:0] != 2'b00) err_d = 1'b1;
        if (halt_hit) state_d = S_HALT;
      end
      S_HALT: begin
`ifdef INST_FEEDER_RELOAD_EN
        // The word offered here only triggers the reload; it is not stored.
        if (load_valid) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
        end
`endif
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      count_q  <= '0;
      inst_q   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      inst_q   <= inst_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[wr_ptr_q] <= load_data;
  end

  assign load_ready = (state_q == S_LOAD);
  assign pcEn       = (state_q == S_RUN);
  assign done       = (state_q == S_HALT);
  assign inst       = inst_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_feeder.sv
// Randomized scoreboard bench for inst_feeder: a queue-based program model predicts inst/halt/err.
module tb_inst_feeder;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DRAIN = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   load_data = 32'h0;
  logic [31:0]   pc = 32'h0;
  logic          load_ready, pcEn, done, err;
  logic [31:0]   inst;
  logic [AW:0]   count;

  int            total = 0;
  int            bad = 0;
  int            mon_n;
  logic [31:0]   prog[$];
  logic [31:0]   stim[$];
  logic [31:0]   exp_q[$];
  bit            exp_err = 1'b0;

  inst_feeder #(.DEPTH(DEPTH), .AW(AW), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .pc(pc),
    .inst(inst), .pcEn(pcEn), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model_inst(input logic [31:0] p);
    if (p >= 32'(4 * DEPTH)) return 32'h0;
    if ((p / 4) >= 32'(prog.size())) return 32'h0;
    return prog[p / 4];
  endfunction

  function automatic bit model_halt(input logic [31:0] p);
    return (p >= 32'(4 * DEPTH)) || ((p / 4) >= 32'(prog.size() + DRAIN));
  endfunction

  // Monitor: every pc driven in RUN produces a registered inst one edge later.
  always @(posedge clk) begin
    mon_n = exp_q.size();
    #1;
    if (mon_n > 0) chk("inst", inst, exp_q.pop_front());
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; start = 1'b0; pc = 32'h0;
    #1;
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pcEn", 32'(pcEn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prog.delete();
    exp_err = 1'b0;
  endtask

  task automatic load_prog(input bit use_last, input bit gappy, input bit start_on_last);
    foreach (stim[i]) begin
      if (gappy) begin
        @(negedge clk);
        load_valid = 1'b0;
      end
      @(negedge clk);
      chk("load_ready_pre", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = stim[i];
      load_last  = use_last && (i == stim.size() - 1);
      start      = start_on_last && load_last;
      prog.push_back(stim[i]);
    end
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    chk("load_ready_post", 32'(load_ready), 32'd0);
    chk("count", 32'(count), 32'(prog.size()));
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pcEn_start", 32'(pcEn), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] p, output bit halted);
    pc = p;
    exp_q.push_back(model_inst(p));
    if (p[1:0] != 2'b00) exp_err = 1'b1;
    halted = model_halt(p);
    @(negedge clk);
    chk("err", 32'(err), 32'(exp_err));
    chk("done", 32'(done), 32'(halted));
    chk("pcEn", 32'(pcEn), 32'(!halted));
  endtask

  task automatic after_halt();
    @(negedge clk);
    chk("halt_inst", inst, 32'h0);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_pcEn", 32'(pcEn), 32'd0);
  endtask

  task automatic run_seq(input logic [31:0] p0);
    bit h = 1'b0;
    logic [31:0] p = p0;
    while (!h) begin
      fetch(p, h);
      p = p + 32'd4;
    end
    after_halt();
  endtask

  task automatic run_random(input int max_cyc);
    bit h = 1'b0;
    logic [31:0] p = 32'h0;
    int c = 0;
    int r;
    while (!h) begin
      c++;
      if (c > max_cyc) p = 32'((prog.size() + DRAIN) * 4);
      fetch(p, h);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: p = p + 32'd4;
        6, 7:             p = p;
        8:                p = 32'(4 * $urandom_range(0, prog.size() - 1));
        default:          p = (p & ~32'h3) + 32'd4 + 32'($urandom_range(1, 3));
      endcase
    end
    after_halt();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    // Directed three-word program; stray starts in LOAD and on the last handshake are dropped.
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_in_load_pcEn", 32'(pcEn), 32'd0);
    chk("start_in_load_ready", 32'(load_ready), 32'd1);
    stim = '{32'h20010005, 32'h20020003, 32'h00221820};
    load_prog(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("start_dropped_pcEn", 32'(pcEn), 32'd0);
    start_run();
    run_seq(32'h0);

    // load_valid while halted.
    @(negedge clk); load_valid = 1'b1; load_data = 32'hdeadbeef;
    @(negedge clk); load_valid = 1'b0;
`ifdef INST_FEEDER_RELOAD_EN
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_ready", 32'(load_ready), 32'd1);
    chk("reload_count", 32'(count), 32'd0);
    prog.delete();
    exp_err = 1'b0;
    stim = '{32'h11111111, 32'h22222222};
    load_prog(1'b1, 1'b0, 1'b0);
    start_run();
    run_seq(32'h0);
`else
    chk("noreload_done", 32'(done), 32'd1);
    chk("noreload_ready", 32'(load_ready), 32'd0);
`endif

    // Misaligned pc sets sticky err; a pc with high bits set halts at once.
    do_reset();
    rand_stim(4);
    load_prog(1'b1, 1'b0, 1'b0);
    start_run();
    fetch(32'h0, h);
    fetch(32'h6, h);
    fetch(32'h8, h);
    fetch(32'h4, h);
    fetch(32'h0001_0000, h);
    after_halt();

    // Async reset in the middle of RUN, then reload and run.
    do_reset();
    rand_stim(5);
    load_prog(1'b1, 1'b0, 1'b0);
    start_run();
    fetch(32'h0, h);
    fetch(32'h4, h);
    pc = 32'h8;
    #2 reset = 1'b0;
    #1;
    chk("midrst_pcEn", 32'(pcEn), 32'd0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    prog.delete();
    exp_err = 1'b0;
    rand_stim(3);
    load_prog(1'b1, 1'b0, 1'b0);
    start_run();
    run_random(200);

    // Full buffer with gappy valid and no load_last; a 65th word is refused.
    do_reset();
    rand_stim(DEPTH);
    load_prog(1'b0, 1'b1, 1'b0);
    @(negedge clk); load_valid = 1'b1; load_data = 32'hcafef00d;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_ready", 32'(load_ready), 32'd0);
    start_run();
    run_random(400);

    // Random programs and random fetch streams.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      rand_stim($urandom_range(1, 40));
      load_prog(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      start_run();
      run_random(300);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
